// File: rtl/tan_pkg.sv
// Shared definitions for the tangent-unit arbiter: FSM encoding, float width, NaN code and watchdog default.
package tan_pkg;

    localparam int          FLOAT_W             = 32;
    localparam logic [31:0] FP_QNAN             = 32'h7FC0_0000;
    localparam int          TAN_TIMEOUT_DEFAULT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage : tan_pkg

// File: rtl/tan_arbiter_rr.sv
// Round-robin pick: first set req bit searching from ptr upward with wrap; combinational, no state.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Walk candidates from farthest to nearest so the slot at ptr ends with top priority.
    always_comb begin
        logic [IW-1:0] cand;
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/tan_arbiter.sv
// Shares one iterative tangent unit between N_REQ requesters with round-robin grants and a watchdog.
// Latency: req to tan_start 1 cycle, qualified done to rsp_valid 1 cycle; new requests only accepted in IDLE.
module tan_arbiter #(
    parameter int N_REQ   = 4,
    parameter int FLOAT_W = tan_pkg::FLOAT_W,
    parameter int TIMEOUT = tan_pkg::TAN_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*FLOAT_W-1:0] angle_in,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [FLOAT_W-1:0]       rsp_result,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic                     tan_start,
    output logic [FLOAT_W-1:0]       tan_angle,
    input  logic                     tan_done,
    input  logic [FLOAT_W-1:0]       tan_result
);
    import tan_pkg::*;

    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t               state;
    state_t               state_nxt;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        grant_idx;
    logic [N_REQ-1:0]     grant_oh;
    logic                 armed;
    logic [WD_W-1:0]      wd_cnt;
    logic [FLOAT_W-1:0]   res_q;

    logic [N_REQ-1:0]     arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 any_req;
    logic                 done_ok;
    logic                 wd_expire;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign any_req = |req;
    // A done only counts once we have seen it low since our own start pulse.
    assign done_ok   = tan_done & armed;
    assign wd_expire = (wd_cnt >= WD_W'(TIMEOUT - 1));
    assign busy      = (state != ST_IDLE);
    assign rsp_result = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_req) state_nxt = ST_START;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT:  if (done_ok || wd_expire) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            grant_idx   <= '0;
            grant_oh    <= '0;
            armed       <= 1'b0;
            wd_cnt      <= '0;
            res_q       <= '0;
            tan_angle   <= '0;
            ack         <= '0;
            tan_start   <= 1'b0;
            rsp_valid   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            ack         <= '0;
            tan_start   <= 1'b0;
            rsp_valid   <= '0;
            rsp_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_idx <= arb_idx;
                        grant_oh  <= arb_grant;
                        tan_angle <= angle_in[int'(arb_idx)*FLOAT_W +: FLOAT_W];
                        ack       <= arb_grant;
                        tan_start <= 1'b1;
                    end
                end
                ST_START: begin
                    ptr    <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
                    wd_cnt <= WD_W'(1);
                    armed  <= 1'b0;
                end
                ST_WAIT: begin
                    armed <= armed | ~tan_done;
                    if (done_ok) begin
                        res_q     <= tan_result;
                        rsp_valid <= grant_oh;
                    end else if (wd_expire) begin
                        res_q       <= FLOAT_W'(FP_QNAN);
                        rsp_valid   <= grant_oh;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : tan_arbiter

// File: tb/tb_tan_arbiter.sv
// Directed bench: two arbiters (default and 64-cycle watchdog) each driving a behavioural tangent stub.
module tb_tan_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [3:0]   req_a = '0, req_b = '0;
    logic [127:0] ang_a = '0, ang_b = '0;
    logic [3:0]   ack_a, ack_b, rv_a, rv_b;
    logic [31:0]  res_a, res_b, tang_a, tang_b;
    logic         to_a, to_b, busy_a, busy_b, st_a, st_b;
    logic         done_a, done_b;
    logic [31:0]  tres_a = '0, tres_b = '0;

    tan_arbiter #(.N_REQ(4), .FLOAT_W(32), .TIMEOUT(4096)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_a), .angle_in(ang_a), .ack(ack_a),
        .rsp_valid(rv_a), .rsp_result(res_a), .rsp_timeout(to_a), .busy(busy_a),
        .tan_start(st_a), .tan_angle(tang_a), .tan_done(done_a), .tan_result(tres_a)
    );

    tan_arbiter #(.N_REQ(4), .FLOAT_W(32), .TIMEOUT(64)) dut_to (
        .clk(clk), .rst_n(rst_n), .req(req_b), .angle_in(ang_b), .ack(ack_b),
        .rsp_valid(rv_b), .rsp_result(res_b), .rsp_timeout(to_b), .busy(busy_b),
        .tan_start(st_b), .tan_angle(tang_b), .tan_done(done_b), .tan_result(tres_b)
    );

    // Tan stubs: age counts cycles since the last start pulse; done answers at a fixed age.
    int age_a = 0, age_b = 0, hold_a = 0;
    bit never_b = 1'b0;

    always @(posedge clk) begin
        if (st_a) begin
            age_a  <= 1;
            tres_a <= tang_a ^ 32'h0000FFFF;
        end else if (age_a != 0 && age_a < 2000) age_a <= age_a + 1;
        if (st_b) begin
            age_b  <= 1;
            tres_b <= tang_b ^ 32'h0000FFFF;
        end else if (age_b != 0 && age_b < 2000) age_b <= age_b + 1;
    end
    assign done_a = (age_a != 0) && ((age_a <= hold_a) || (age_a >= 600));
    assign done_b = (age_b != 0) && !never_b && (age_b >= 20);

    logic sel = 1'b0;
    wire        m_busy  = sel ? busy_b : busy_a;
    wire        m_start = sel ? st_b   : st_a;
    wire [3:0]  m_ack   = sel ? ack_b  : ack_a;
    wire [3:0]  m_rv    = sel ? rv_b   : rv_a;
    wire [31:0] m_tang  = sel ? tang_b : tang_a;
    wire [31:0] m_res   = sel ? res_b  : res_a;
    wire        m_to    = sel ? to_b   : to_a;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit           sel;
        logic [3:0]   rq;
        logic [127:0] ang;
        logic [3:0]   e_ack;
        logic [31:0]  e_ang;
        logic [31:0]  e_res;
        logic         e_to;
        int           e_lat;
        int           hold;
        bit           never;
        string        name;
    } vec_t;

    // Entry: IDLE at a negedge. Exit: IDLE at a negedge, requests cleared.
    task automatic run_op(input vec_t v);
        int n, starts, unstable;
        sel     = v.sel;
        hold_a  = v.hold;
        never_b = v.never;
        chk({v.name, " idle busy"}, m_busy, 0);
        if (v.sel) begin req_b = v.rq; ang_b = v.ang; end
        else       begin req_a = v.rq; ang_a = v.ang; end
        n = 0;
        do begin @(negedge clk); n++; end while (!m_start && n < 8);
        chk({v.name, " start latency"}, n, 1);
        chk({v.name, " ack"}, m_ack, v.e_ack);
        chk({v.name, " tan_angle"}, m_tang, v.e_ang);
        starts = 1; unstable = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (m_start) starts++;
            if (m_tang !== v.e_ang) unstable++;
            if (n == 1) chk({v.name, " ack pulse"}, m_ack, 0);
        end while (m_rv == 0 && n < v.e_lat + 20);
        chk({v.name, " rsp latency"}, n, v.e_lat);
        chk({v.name, " rsp_valid"}, m_rv, v.e_ack);
        chk({v.name, " rsp_result"}, m_res, v.e_res);
        chk({v.name, " rsp_timeout"}, m_to, v.e_to);
        chk({v.name, " start pulses"}, starts, 1);
        chk({v.name, " angle unstable"}, unstable, 0);
        @(negedge clk);
        chk({v.name, " rsp pulse"}, m_rv, 0);
        req_a = '0;
        req_b = '0;
    endtask

    localparam logic [127:0] RR_ANG = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

    vec_t vecs[10];
    vec_t post_rst;

    initial begin
        vecs[0] = '{1'b0, 4'b1111, RR_ANG, 4'b0001, 32'h3F800000, 32'h3F80FFFF, 1'b0, 601, 0, 1'b0, "rr0"};
        vecs[1] = '{1'b0, 4'b1111, RR_ANG, 4'b0010, 32'h40000000, 32'h4000FFFF, 1'b0, 601, 0, 1'b0, "rr1"};
        vecs[2] = '{1'b0, 4'b1111, RR_ANG, 4'b0100, 32'h40400000, 32'h4040FFFF, 1'b0, 601, 0, 1'b0, "rr2"};
        vecs[3] = '{1'b0, 4'b1111, RR_ANG, 4'b1000, 32'h40800000, 32'h4080FFFF, 1'b0, 601, 0, 1'b0, "rr3"};
        vecs[4] = '{1'b0, 4'b1111, RR_ANG, 4'b0001, 32'h3F800000, 32'h3F80FFFF, 1'b0, 601, 0, 1'b0, "rr4"};
        vecs[5] = '{1'b0, 4'b0001, {96'h0, 32'h3FC00000}, 4'b0001, 32'h3FC00000, 32'h3FC0FFFF,
                    1'b0, 601, 0, 1'b0, "single"};
        vecs[6] = '{1'b0, 4'b0100, {32'h0, 32'h40490FDB, 64'h0}, 4'b0100, 32'h40490FDB, 32'h4049F024,
                    1'b0, 601, 3, 1'b0, "stale"};
        vecs[7] = '{1'b0, 4'b1000, {32'hC011361E, 96'h0}, 4'b1000, 32'hC011361E, 32'hC011C9E1,
                    1'b0, 601, 0, 1'b0, "passthru"};
        vecs[8] = '{1'b1, 4'b0100, {32'h0, 32'h3F000000, 64'h0}, 4'b0100, 32'h3F000000, 32'h7FC00000,
                    1'b1, 64, 0, 1'b1, "timeout"};
        vecs[9] = '{1'b1, 4'b0001, {96'h0, 32'h3E800000}, 4'b0001, 32'h3E800000, 32'h3E80FFFF,
                    1'b0, 21, 0, 1'b0, "recover"};
        post_rst = '{1'b0, 4'b0110, {32'h0, 32'h40A00000, 32'h40C00000, 32'h0}, 4'b0010, 32'h40C00000,
                     32'h40C0FFFF, 1'b0, 601, 0, 1'b0, "post_rst"};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", {busy_a, busy_b}, 0);
        chk("rst ack", {ack_a, ack_b}, 0);
        chk("rst rsp_valid", {rv_a, rv_b}, 0);
        chk("rst tan_start", {st_a, st_b}, 0);
        chk("rst tan_angle", {tang_a, tang_b}, 0);
        chk("rst rsp_result/timeout", {res_a, to_a, res_b, to_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Reset while requester 1 is mid-WAIT; ptr would be 2 if reset failed to clear it.
        sel    = 1'b0;
        hold_a = 0;
        req_a  = 4'b0010;
        ang_a  = {64'h0, 32'h3F400000, 32'h0};
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!st_a && n < 8);
            chk("midwait start seen", st_a, 1);
        end
        repeat (10) @(negedge clk);
        chk("midwait busy", busy_a, 1);
        req_a = '0;
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("midrst busy", busy_a, 0);
            chk("midrst rsp_valid", rv_a, 0);
            chk("midrst outs", {ack_a, st_a, tang_a}, 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("postrst quiet", {rv_a, busy_a}, 0);
        end
        run_op(post_rst);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tan_arbiter
